// File: rtl/lsu_if.sv
// Bus bundle for the load/store unit: EX-stage request, data-memory strobes and completion response.
// The LSU is the slave of the request channel and drives the memory and response signals.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport slave (
        input  req_valid, req_opcode, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_addr, mem_read, mem_write, mem_wdata,
        output resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_opcode, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_addr, mem_read, mem_write, mem_wdata,
        input  resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// MIPS load/store unit: byte/half/word loads with extension, sub-word stores by read-modify-write.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses with resp_err.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | req_ready high, waiting for a request
// RD_REQ  | mem_read strobe asserted for the latched word address
// RD_WAIT | mem_rdata valid; load result or store merge computed
// WR      | mem_write strobe asserted with the full word
// DONE    | resp_valid pulse, resp_data/resp_err updated
module load_store_unit (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;

    logic [31:0] mem_wdata_next;
    logic [31:0] resp_data_next;
    logic        resp_err_next;

    logic        accept;
    logic        req_supported;
    logic        req_misaligned;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic [31:0] load_extend(
        input logic [5:0]  op,
        input logic [1:0]  lane,
        input logic [31:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lane, 3'b000} +: 8];
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h000000, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0000, h};
            default: return rdata;
        endcase
    endfunction

    // Only the addressed lane is replaced; the rest of the word comes back from memory.
    function automatic logic [31:0] store_merge(
        input logic [5:0]  op,
        input logic [1:0]  lane,
        input logic [31:0] wdata,
        input logic [31:0] rdata
    );
        logic [31:0] w;
        w = rdata;
        if (op == OP_SB) begin
            w[{lane, 3'b000} +: 8] = wdata[7:0];
        end else if (lane[1]) begin
            w[31:16] = wdata[15:0];
        end else begin
            w[15:0] = wdata[15:0];
        end
        return w;
    endfunction

    assign accept        = (state == IDLE) && bus.req_valid;
    assign req_supported = is_load(bus.req_opcode) || is_store(bus.req_opcode);

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        req_misaligned = 1'b0;
        case (bus.req_opcode)
            OP_LH, OP_LHU, OP_SH: req_misaligned = bus.req_addr[0];
            OP_LW, OP_SW:         req_misaligned = (bus.req_addr[1:0] != 2'b00);
            default:              req_misaligned = 1'b0;
        endcase
    end
`else
    assign req_misaligned = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        mem_wdata_next = mem_wdata_q;
        resp_data_next = resp_data_q;
        resp_err_next  = resp_err_q;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!req_supported || req_misaligned) begin
                        state_next     = DONE;
                        resp_data_next = 32'h0;
                        resp_err_next  = 1'b1;
                    end else if (bus.req_opcode == OP_SW) begin
                        state_next     = WR;
                        mem_wdata_next = bus.req_wdata;
                    end else begin
                        state_next     = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (is_load(op_q)) begin
                    state_next     = DONE;
                    resp_data_next = load_extend(op_q, lane_q, bus.mem_rdata);
                    resp_err_next  = 1'b0;
                end else begin
                    state_next     = WR;
                    mem_wdata_next = store_merge(op_q, lane_q, wdata_q, bus.mem_rdata);
                end
            end
            WR: begin
                state_next     = DONE;
                resp_data_next = 32'h0;
                resp_err_next  = 1'b0;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes and the response pulse are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= 6'h00;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state        <= state_next;
            mem_read_q   <= (state_next == RD_REQ);
            mem_write_q  <= (state_next == WR);
            resp_valid_q <= (state_next == DONE);
            mem_wdata_q  <= mem_wdata_next;
            resp_data_q  <= resp_data_next;
            resp_err_q   <= resp_err_next;
            if (accept) begin
                op_q       <= bus.req_opcode;
                lane_q     <= bus.req_addr[1:0];
                wdata_q    <= bus.req_wdata;
                mem_addr_q <= {2'b00, bus.req_addr[31:2]};
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 req_valid  in  1  memory request presented by EX stage.
REQ-004 req_ready  out  1  unit idle, can accept a request this cycle.
REQ-005 req_opcode  in  6  MIPS opcode: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B.
REQ-006 req_addr  in  32  byte address computed by ALU.
REQ-007 req_wdata  in  32  store data (rt); low byte/halfword used for sb/sh.
REQ-008 mem_addr  out  32  word index to data memory = {2'b00, addr[31:2]}.
REQ-009 mem_read / mem_write  out  1 each  memory strobes; never both high.
REQ-010 mem_wdata  out  32  full word written to memory.
REQ-011 mem_rdata  in  32  memory read data, valid the cycle after mem_read is high.
REQ-012 resp_valid  out  1  one-cycle pulse: operation complete.
REQ-013 resp_data  out  32  extended load result; 0 for stores and errors.
REQ-014 resp_err  out  1  qualifies resp_valid: request rejected, no memory access made.

Function
REQ-015 FSM states IDLE, RD_REQ, RD_WAIT, WR, DONE; req_ready=1 only in IDLE.
REQ-016 Accept when req_valid & req_ready; opcode, addr, wdata latched into internal registers at accept edge.
REQ-017 Load: IDLE->RD_REQ (mem_read=1)->RD_WAIT (capture mem_rdata)->DONE (resp_valid=1)->IDLE; resp_valid 3 cycles after accept.
REQ-018 sw: IDLE->WR (mem_write=1, mem_wdata=wdata)->DONE->IDLE; resp_valid 2 cycles after accept.
REQ-019 sb/sh: read-modify-write IDLE->RD_REQ->RD_WAIT (merge)->WR->DONE->IDLE; resp_valid 4 cycles after accept.
REQ-020 Byte lanes little-endian: lane = addr[1:0] for bytes, addr[1] for halfwords; merge replaces only the addressed lane, other bits preserved from mem_rdata.
REQ-021 lb/lh sign-extend selected lane to 32 bits; lbu/lhu zero-extend; lw passes word unchanged.
REQ-022 Unsupported opcode: IDLE->DONE, resp_err=1, resp_data=0, no memory strobe.
REQ-023 mem_addr held constant from RD_REQ through WR of one operation; strobes are registered outputs, low in IDLE/RD_WAIT/DONE.
REQ-024 req_valid high outside IDLE is ignored (not queued); requester holds it until req_ready.
REQ-025 resp_data/resp_err hold last value until next DONE; resp_valid high exactly one cycle per accepted request.

Reset
REQ-026 rst_n low at a rising edge: FSM->IDLE; req_ready=1; mem_read=mem_write=0; resp_valid=0, resp_err=0; resp_data=0; mem_addr=0; mem_wdata=0.
REQ-027 Reset mid-operation aborts it; no write strobe issued after the reset edge, no resp_valid for the aborted request.

Configuration
REQ-028 Macro LSU_MISALIGN_CHECK_EN defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, go IDLE->DONE with resp_err=1, no strobes.
REQ-029 Macro undefined: no alignment check; halfword lane uses addr[1], word ignores addr[1:0]; resp_err only for unsupported opcodes.

Verification
REQ-030 Mem word 1 = 0x8899AABB; lb addr 0x5 -> mem_read at accept+1, mem_addr=1, resp_valid at accept+3, resp_data=0xFFFFFFAA.
REQ-031 Same word; lbu 0x5 -> 0x000000AA; lhu 0x6 -> 0x00008899; lh 0x6 -> 0xFFFF8899.
REQ-032 sh addr 0x4 wdata 0xDEAD1234 on 0x8899AABB -> one mem_read, then mem_write with mem_wdata=0x88991234, resp_valid at accept+4.
REQ-033 sw addr 0x8 wdata 0xCAFEF00D -> mem_write at accept+1, mem_addr=2, no mem_read, resp_valid at accept+2, resp_err=0.
REQ-034 lw addr 0x6: with LSU_MISALIGN_CHECK_EN -> resp_err=1 at accept+1, no strobes; without -> reads word 1.
REQ-035 sb accepted, rst_n low during RD_WAIT -> mem_write never asserted, all outputs at reset values, req_ready=1 next cycle.
